// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl
//   Owns the character-code RAM behind the on-screen text window
//   (X_LETTERS x Y_LETTERS cells). It serves the render stage's char_xy
//   lookup with a registered char_code one cycle after the request. It
//   arbitrates round-robin between two game-logic writers that use req/ack
//   handshakes. It also blanks the whole buffer after reset and on clr_req.
//
// Ports
//   pclk       pixel clock, all state on the rising edge
//   rst        synchronous active-high reset
//   char_xy    read coordinate, [15:8] = column x, [7:0] = row y
//   char_code  registered code for char_xy sampled on the previous edge
//   req0/x0/y0/data0/ack0  requester 0 write handshake (ack is a 1-cycle pulse)
//   req1/x1/y1/data1/ack1  requester 1 write handshake
//   clr_req    starts a full-buffer clear when idle
//   busy       high while a clear is in progress
module text_buffer_ctrl #(
    parameter int unsigned X_LETTERS  = 16,
    parameter int unsigned Y_LETTERS  = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [7:0]  BLANK_CODE = 8'h20
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [15:0] char_xy,
    output logic [7:0]  char_code,
    input  logic        req0,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    input  logic [7:0]  data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  x1,
    input  logic [7:0]  y1,
    input  logic [7:0]  data1,
    output logic        ack1,
    input  logic        clr_req,
    output logic        busy
);

    localparam int unsigned Cells    = X_LETTERS * Y_LETTERS;
    localparam int unsigned MemDepth = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Cells - 1);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // Compares are done at full width so that wrapped (negative) render
    // offsets fall out of range rather than aliasing onto a valid cell.
    function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
        return (32'(x) < X_LETTERS) && (32'(y) < Y_LETTERS);
    endfunction

    // Truncation to ADDR_W happens only after the range check.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
        return ADDR_W'(32'(y) * X_LETTERS + 32'(x));
    endfunction

    logic [7:0] mem [MemDepth];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              rr_last_q, rr_last_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [7:0]        char_code_q, char_code_d;

    logic              elig0, elig1;
    logic              gnt0, gnt1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic [7:0]        rd_x, rd_y;

    // A requester still holding req during its ack cycle is not eligible;
    // this keeps one handshake from producing two writes.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt0 = elig0 & (~elig1 | rr_last_q);
    assign gnt1 = elig1 & (~elig0 | ~rr_last_q);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rr_last_d  = rr_last_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = clr_addr_q;
        wr_data    = BLANK_CODE;

        unique case (state_q)
            StClear: begin
                wr_en = 1'b1;
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StIdle: begin
                // A clear beats any write sampled in the same cycle; the
                // request stays pending and is served after the clear.
                if (clr_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else if (gnt0) begin
                    ack0_d    = 1'b1;
                    rr_last_d = 1'b0;
                    wr_en     = in_range(x0, y0);
                    wr_addr   = cell_addr(x0, y0);
                    wr_data   = data0;
                end else if (gnt1) begin
                    ack1_d    = 1'b1;
                    rr_last_d = 1'b1;
                    wr_en     = in_range(x1, y1);
                    wr_addr   = cell_addr(x1, y1);
                    wr_data   = data1;
                end
            end
            default: begin
                state_d    = StClear;
                clr_addr_d = '0;
            end
        endcase
    end

    assign rd_x = char_xy[15:8];
    assign rd_y = char_xy[7:0];

    always_comb begin
        char_code_d = BLANK_CODE;
        if (state_q != StClear && in_range(rd_x, rd_y)) begin
            char_code_d = mem[cell_addr(rd_x, rd_y)];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            rr_last_q   <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            char_code_q <= BLANK_CODE;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rr_last_q   <= rr_last_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            char_code_q <= char_code_d;
        end
    end

    // No reset on the array: the clear sequence overwrites it. Nonblocking
    // update gives read-first behaviour against the read port above.
    always_ff @(posedge pclk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign char_code = char_code_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = (state_q == StClear);

endmodule

// File: tb/tb_text_buffer_ctrl.sv
module tb_text_buffer_ctrl;

    logic        pclk;
    logic        rst;
    logic [15:0] char_xy;
    logic [7:0]  char_code;
    logic        req0, req1;
    logic [7:0]  x0, y0, data0, x1, y1, data1;
    logic        ack0, ack1;
    logic        clr_req;
    logic        busy;

    int total = 0;
    int bad   = 0;

    text_buffer_ctrl dut (
        .pclk      (pclk),
        .rst       (rst),
        .char_xy   (char_xy),
        .char_code (char_code),
        .req0      (req0),
        .x0        (x0),
        .y0        (y0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .x1        (x1),
        .y1        (y1),
        .data1     (data1),
        .ack1      (ack1),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n;
    int blank_bad;
    int hits;
    logic ack_seen;

    initial begin
        rst = 1'b1; char_xy = 16'h0305; clr_req = 1'b0;
        req0 = 1'b0; x0 = '0; y0 = '0; data0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0; data1 = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_code", 32'(char_code), 32'h20);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);

        // Initial clear: busy falls exactly 256 edges after release
        rst = 1'b0;
        n = 0; blank_bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (char_code !== 8'h20) blank_bad++;
            if (!busy) break;
        end
        check("init_clear_len", 32'(n), 32'd256);
        check("init_clear_blank", 32'(blank_bad), 32'd0);

        // Contention: acks alternate starting with ack0
        req0 = 1'b1; x0 = 8'd1; y0 = 8'd5; data0 = 8'hA0;
        req1 = 1'b1; x1 = 8'd2; y1 = 8'd5; data1 = 8'hB0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_ack0", 32'(ack0), 32'((k % 2) == 0));
            check("rr_ack1", 32'(ack1), 32'((k % 2) == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("rr_idle_acks", 32'({ack0, ack1}), 32'd0);
        // Last grant was requester 0, so a fresh tie goes to requester 1
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("rr_tie_ack0", 32'(ack0), 32'd0);
        check("rr_tie_ack1", 32'(ack1), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        char_xy = 16'h0105; tick();
        check("rr_cell_1_5", 32'(char_code), 32'hA0);
        char_xy = 16'h0205; tick();
        check("rr_cell_2_5", 32'(char_code), 32'hB0);

        // Lone write; new data presented in the ack cycle must not land
        req0 = 1'b1; x0 = 8'd3; y0 = 8'd2; data0 = 8'h41;
        tick();
        check("w_ack0_pulse", 32'(ack0), 32'd1);
        data0 = 8'h42;
        tick();
        check("w_ack0_single", 32'(ack0), 32'd0);
        req0 = 1'b0;
        char_xy = 16'h0302; tick();
        check("w_read_3_2", 32'(char_code), 32'h41);

        // Out-of-range write is acked but leaves RAM untouched
        req0 = 1'b1; x0 = 8'd16; y0 = 8'd0; data0 = 8'h55;
        tick();
        check("oor_ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick();
        hits = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                char_xy = {8'(x), 8'(y)};
                tick();
                if (char_code === 8'h55) hits++;
            end
        end
        check("oor_sweep_hits", 32'(hits), 32'd0);
        char_xy = 16'h00FF; tick();
        check("oor_read_y255", 32'(char_code), 32'h20);
        char_xy = 16'h1000; tick();
        check("oor_read_x16", 32'(char_code), 32'h20);

        // Fill (1,1) then clear with a pending write in the same cycle
        req0 = 1'b1; x0 = 8'd1; y0 = 8'd1; data0 = 8'h7A;
        tick();
        req0 = 1'b0;
        tick();
        char_xy = 16'h0101; tick();
        check("fill_1_1", 32'(char_code), 32'h7A);
        clr_req = 1'b1;
        req1 = 1'b1; x1 = 8'd1; y1 = 8'd1; data1 = 8'h33;
        tick();
        check("clr_busy_rise", 32'(busy), 32'd1);
        check("clr_no_ack1", 32'(ack1), 32'd0);
        n = 0; ack_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            // A second clr_req mid-clear must not extend it
            clr_req = (n == 100);
            tick();
            n++;
            if (ack1 || ack0) ack_seen = 1'b1;
            if (!busy) break;
        end
        clr_req = 1'b0;
        check("clr_len", 32'(n), 32'd256);
        check("clr_acks_held", 32'(ack_seen), 32'd0);
        tick();
        check("clr_ack1_after", 32'(ack1), 32'd1);
        check("clr_cell_wiped", 32'(char_code), 32'h20);
        req1 = 1'b0;
        tick();
        check("clr_write_lands", 32'(char_code), 32'h33);
        check("clr_ack1_drop", 32'(ack1), 32'd0);

        // Reset at cycle 100 of a clear restarts it
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(); tick();
        check("mid_rst_acks", 32'({ack0, ack1}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (!busy) break;
        end
        check("mid_restart_len", 32'(n), 32'd256);
        tick();
        check("mid_cell_blank", 32'(char_code), 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
